// File: rtl/noc_local_ni_if.sv
// ==========================================================================
// noc_local_ni_if : host-side and router-side signal bundle for the NI. Rev 1.0
// ==========================================================================
`default_nettype none

interface noc_local_ni_if #(
  parameter int TAM_FLIT = 16
);
  // host inject
  logic                tx_valid;
  logic [TAM_FLIT-1:0] tx_data;
  logic [TAM_FLIT-1:0] tx_dest;
  logic                tx_last;
  logic                tx_ready;
  logic                tx_trunc;
  // router LOCAL port
  logic                router_rx;
  logic [TAM_FLIT-1:0] router_rx_data;
  logic                router_credit;
  logic                router_tx;
  logic [TAM_FLIT-1:0] router_tx_data;
  logic                ni_credit;
  // host eject
  logic                rx_valid;
  logic [TAM_FLIT-1:0] rx_data;
  logic                rx_last;
  logic                rx_ready;

  modport slave (
    input  tx_valid, tx_data, tx_dest, tx_last,
    input  router_credit, router_tx, router_tx_data, rx_ready,
    output tx_ready, tx_trunc, router_rx, router_rx_data, ni_credit,
    output rx_valid, rx_data, rx_last
  );

  modport master (
    output tx_valid, tx_data, tx_dest, tx_last,
    output router_credit, router_tx, router_tx_data, rx_ready,
    input  tx_ready, tx_trunc, router_rx, router_rx_data, ni_credit,
    input  rx_valid, rx_data, rx_last
  );
endinterface

`default_nettype wire

// File: rtl/noc_local_ni.sv
// ==========================================================================
// noc_local_ni : LOCAL-port NI, frames host payload into packets and strips ejected ones. Rev 1.0
// ==========================================================================
`default_nettype none

module noc_local_ni #(
  parameter int                  TAM_FLIT = 16,
  parameter logic [TAM_FLIT-1:0] ADDRESS  = '0,
  parameter int                  TX_DEPTH = 8,
  parameter int                  RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  noc_local_ni_if.slave link,
  output logic        misroute,
  output logic [15:0] pkt_sent,
  output logic [15:0] pkt_recv
);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam int TXC = TXW + 1;
  localparam int RXW = $clog2(RX_DEPTH);
  localparam int RXC = RXW + 1;

  typedef enum logic [1:0] {LOAD, HDR, SIZE, PAY} inj_state_t;
  typedef enum logic [1:0] {EHDR, ESIZE, EPAY}    ej_state_t;

  // Holds handshake outputs low until the first clock after reset release.
  logic active;

  inj_state_t          inj_state, inj_next;
  logic [TAM_FLIT-1:0] tx_mem [TX_DEPTH];
  logic [TAM_FLIT-1:0] dest;
  logic [TXC-1:0]      wr_cnt;
  logic [TXC-1:0]      wr_last;
  logic [TXW-1:0]      rd_ptr;
  logic                tx_accept;
  logic                pay_done;

  assign wr_last  = wr_cnt - TXC'(1);
  assign pay_done = (inj_state == PAY) && link.router_credit && (TXC'(rd_ptr) == wr_last);

  always_comb begin
    inj_next            = inj_state;
    tx_accept           = 1'b0;
    link.tx_ready       = 1'b0;
    link.tx_trunc       = 1'b0;
    link.router_rx      = 1'b0;
    link.router_rx_data = '0;
    case (inj_state)
      LOAD: begin
        link.tx_ready = active;
        tx_accept     = active && link.tx_valid;
        if (tx_accept && (link.tx_last || wr_cnt == TXC'(TX_DEPTH - 1))) begin
          inj_next      = HDR;
          link.tx_trunc = !link.tx_last;
        end
      end
      HDR: begin
        link.router_rx      = 1'b1;
        link.router_rx_data = dest;
        if (link.router_credit) inj_next = SIZE;
      end
      SIZE: begin
        link.router_rx      = 1'b1;
        link.router_rx_data = TAM_FLIT'(wr_cnt);
        if (link.router_credit) inj_next = PAY;
      end
      PAY: begin
        link.router_rx      = 1'b1;
        link.router_rx_data = tx_mem[rd_ptr];
        if (pay_done) inj_next = LOAD;
      end
      default: inj_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      inj_state <= LOAD;
      dest      <= '0;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      pkt_sent  <= '0;
    end else begin
      active    <= 1'b1;
      inj_state <= inj_next;
      if (tx_accept) begin
        if (wr_cnt == '0) dest <= link.tx_dest;
        wr_cnt <= wr_cnt + TXC'(1);
      end
      if (inj_state == PAY && link.router_credit) begin
        if (pay_done) begin
          rd_ptr   <= '0;
          wr_cnt   <= '0;
          pkt_sent <= pkt_sent + 16'd1;
        end else begin
          rd_ptr <= rd_ptr + TXW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_accept) tx_mem[wr_cnt[TXW-1:0]] <= link.tx_data;
  end

  ej_state_t           ej_state, ej_next;
  logic [TAM_FLIT-1:0] remaining;
  logic [TAM_FLIT:0]   rx_mem [RX_DEPTH];
  logic [RXW-1:0]      wptr, rptr;
  logic [RXC-1:0]      count;
  logic                ej_accept, push, pop, push_last;

  assign ej_accept     = link.router_tx && link.ni_credit;
  assign push_last     = (remaining == TAM_FLIT'(1));
  assign link.rx_valid = (count != '0);
  assign pop           = link.rx_valid && link.rx_ready;
  assign link.rx_data  = link.rx_valid ? rx_mem[rptr][TAM_FLIT-1:0] : '0;
  assign link.rx_last  = link.rx_valid && rx_mem[rptr][TAM_FLIT];

  always_comb begin
    ej_next        = ej_state;
    push           = 1'b0;
    link.ni_credit = 1'b0;
    case (ej_state)
      EHDR: begin
        link.ni_credit = active;
        if (ej_accept) ej_next = ESIZE;
      end
      ESIZE: begin
        link.ni_credit = active;
        if (ej_accept) ej_next = (link.router_tx_data == '0) ? EHDR : EPAY;
      end
      EPAY: begin
        // Credit comes from the registered count only, so host ready never reaches the router.
        link.ni_credit = active && (count != RXC'(RX_DEPTH));
        push           = ej_accept;
        if (ej_accept && push_last) ej_next = EHDR;
      end
      default: ej_next = EHDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ej_state  <= EHDR;
      remaining <= '0;
      misroute  <= 1'b0;
      pkt_recv  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
    end else begin
      ej_state <= ej_next;
      if (ej_state == EHDR && ej_accept && link.router_tx_data != ADDRESS) misroute <= 1'b1;
      if (ej_state == ESIZE && ej_accept) begin
        remaining <= link.router_tx_data;
        if (link.router_tx_data == '0) pkt_recv <= pkt_recv + 16'd1;
      end
      if (push) begin
        remaining <= remaining - TAM_FLIT'(1);
        wptr      <= wptr + RXW'(1);
        if (push_last) pkt_recv <= pkt_recv + 16'd1;
      end
      if (pop) rptr <= rptr + RXW'(1);
      case ({push, pop})
        2'b10:   count <= count + RXC'(1);
        2'b01:   count <= count - RXC'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) rx_mem[wptr] <= {push_last, link.router_tx_data};
  end
endmodule

`default_nettype wire

// File: tb/tb_noc_local_ni.sv
// ==========================================================================
// tb_noc_local_ni : randomized self-checking bench against a queue-based packet model. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_noc_local_ni;
  localparam int          W    = 16;
  localparam logic [15:0] ADDR = 16'h0203;
  localparam int          TXD  = 8;
  localparam int          RXD  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_local_ni_if #(.TAM_FLIT(W)) link ();
  logic        misroute;
  logic [15:0] pkt_sent, pkt_recv;

  noc_local_ni #(.TAM_FLIT(W), .ADDRESS(ADDR), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .link(link),
    .misroute(misroute), .pkt_sent(pkt_sent), .pkt_recv(pkt_recv)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] flit_q[$];
  logic [16:0] ej_q[$];
  logic [15:0] exp_flits[$];
  logic [16:0] exp_ej[$];
  bit acc_tx, acc_ej, rand_credit, rand_ready;
  int trunc_cnt;
  int exp_sent, exp_recv;
  bit exp_mis;

  // One clock: apply pending inputs, observe transfers just before the edge, move to next negedge.
  task automatic step();
    if (rand_credit) link.router_credit = ($urandom_range(0, 3) != 0);
    if (rand_ready) link.rx_ready = ($urandom_range(0, 1) == 1);
    #1;
    acc_tx = link.tx_valid && link.tx_ready;
    acc_ej = link.router_tx && link.ni_credit;
    if (link.router_rx && link.router_credit) flit_q.push_back(link.router_rx_data);
    if (link.rx_valid && link.rx_ready) ej_q.push_back({link.rx_last, link.rx_data});
    if (link.tx_trunc) trunc_cnt++;
    @(negedge clk);
  endtask

  // Host side of one packet; the model frame (dest, count, words) goes to exp_flits.
  task automatic inject_pkt(input logic [15:0] dest, input int n, input bit with_last, input bit bursty);
    logic [15:0] words[$];
    int i = 0;
    int budget = 0;
    int kept;
    for (int k = 0; k < n; k++) words.push_back(16'($urandom));
    kept = (n > TXD) ? TXD : n;
    exp_flits.delete();
    exp_flits.push_back(dest);
    exp_flits.push_back(16'(kept));
    for (int k = 0; k < kept; k++) exp_flits.push_back(words[k]);
    while (i < n && budget < 1000) begin
      link.tx_valid = bursty ? ($urandom_range(0, 2) != 0) : 1'b1;
      link.tx_data  = words[i];
      link.tx_dest  = (i == 0) ? dest : 16'($urandom);
      link.tx_last  = with_last && (i == n - 1);
      step();
      if (acc_tx) i++;
      budget++;
    end
    link.tx_valid = 1'b0;
    link.tx_last  = 1'b0;
    if (i < n) begin
      total++; bad++;
      $display("FAIL inject_accept got=%0d words required=%0d", i, n);
    end
  endtask

  task automatic wait_flits(input int n);
    int budget = 0;
    while (flit_q.size() < n && budget < 1000) begin
      step();
      budget++;
    end
    if (flit_q.size() < n) begin
      total++; bad++;
      $display("FAIL flit_timeout got=%0d flits required=%0d", flit_q.size(), n);
    end
  endtask

  task automatic send_flit(input logic [15:0] f);
    int budget = 0;
    link.router_tx      = 1'b1;
    link.router_tx_data = f;
    acc_ej = 1'b0;
    while (!acc_ej && budget < 1000) begin
      step();
      budget++;
    end
    link.router_tx = 1'b0;
    if (!acc_ej) begin
      total++; bad++;
      $display("FAIL eject_accept got=stalled required=accepted flit=%h", f);
    end
  endtask

  task automatic wait_eject(input int n);
    int budget = 0;
    while (ej_q.size() < n && budget < 1000) begin
      step();
      budget++;
    end
  endtask

  task automatic test_reset();
    link.tx_valid = 0; link.tx_data = 0; link.tx_dest = 0; link.tx_last = 0;
    link.router_credit = 0; link.router_tx = 0; link.router_tx_data = 0; link.rx_ready = 0;
    rand_credit = 0; rand_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (link.tx_ready !== 1'b0) begin bad++; $display("FAIL rst_tx_ready got=%b exp=0", link.tx_ready); end
    total++; if (link.ni_credit !== 1'b0) begin bad++; $display("FAIL rst_credit got=%b exp=0", link.ni_credit); end
    total++; if ({link.router_rx, link.rx_valid, link.tx_trunc, misroute} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=0000", {link.router_rx, link.rx_valid, link.tx_trunc, misroute}); end
    total++; if ({pkt_sent, pkt_recv} !== 32'h0) begin
      bad++; $display("FAIL rst_counters got=%h exp=00000000", {pkt_sent, pkt_recv}); end
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    total++; if (link.tx_ready !== 1'b1 || link.ni_credit !== 1'b1) begin
      bad++; $display("FAIL post_rst_ready got=%b%b exp=11", link.tx_ready, link.ni_credit); end
    exp_sent = 0; exp_recv = 0; exp_mis = 0;
  endtask

  task automatic test_inject_basic();
    link.router_credit = 1'b1;
    flit_q.delete();
    inject_pkt(16'h0102, 3, 1'b1, 1'b0);
    repeat (5) step();
    total++; if (flit_q.size() !== 5) begin bad++; $display("FAIL basic_consecutive got=%0d flits exp=5", flit_q.size()); end
    for (int k = 0; k < exp_flits.size() && k < flit_q.size(); k++) begin
      total++; if (flit_q[k] !== exp_flits[k]) begin bad++; $display("FAIL basic_flit[%0d] got=%h exp=%h", k, flit_q[k], exp_flits[k]); end
    end
    exp_sent++;
    total++; if (pkt_sent !== 16'(exp_sent)) begin bad++; $display("FAIL basic_pkt_sent got=%0d exp=%0d", pkt_sent, exp_sent); end
  endtask

  task automatic test_credit_stall();
    logic [15:0] held;
    link.router_credit = 1'b1;
    flit_q.delete();
    inject_pkt(16'h0300, 6, 1'b1, 1'b0);
    wait_flits(3);
    link.router_credit = 1'b0;
    step();
    held = link.router_rx_data;
    total++; if (held !== exp_flits[3]) begin bad++; $display("FAIL stall_held got=%h exp=%h", held, exp_flits[3]); end
    repeat (3) begin
      step();
      total++; if (link.router_rx !== 1'b1 || link.router_rx_data !== held) begin
        bad++; $display("FAIL stall_stable got=%b/%h exp=1/%h", link.router_rx, link.router_rx_data, held); end
    end
    total++; if (flit_q.size() !== 3) begin bad++; $display("FAIL stall_no_xfer got=%0d exp=3", flit_q.size()); end
    link.router_credit = 1'b1;
    wait_flits(exp_flits.size());
    for (int k = 0; k < exp_flits.size() && k < flit_q.size(); k++) begin
      total++; if (flit_q[k] !== exp_flits[k]) begin bad++; $display("FAIL stall_flit[%0d] got=%h exp=%h", k, flit_q[k], exp_flits[k]); end
    end
    exp_sent++;
  endtask

  task automatic test_truncate();
    link.router_credit = 1'b1;
    flit_q.delete();
    trunc_cnt = 0;
    inject_pkt(16'h0011, TXD - 1, 1'b0, 1'b0);
    total++; if (trunc_cnt !== 0) begin bad++; $display("FAIL trunc_early got=%0d exp=0", trunc_cnt); end
    link.tx_valid = 1'b1; link.tx_data = 16'hBEEF; link.tx_last = 1'b0;
    exp_flits[1] = 16'(TXD);
    exp_flits.push_back(16'hBEEF);
    step();
    link.tx_valid = 1'b0;
    total++; if (trunc_cnt !== 1) begin bad++; $display("FAIL trunc_pulse got=%0d exp=1", trunc_cnt); end
    wait_flits(exp_flits.size());
    total++; if (flit_q[1] !== 16'h0008) begin bad++; $display("FAIL trunc_size got=%h exp=0008", flit_q[1]); end
    for (int k = 0; k < exp_flits.size() && k < flit_q.size(); k++) begin
      total++; if (flit_q[k] !== exp_flits[k]) begin bad++; $display("FAIL trunc_flit[%0d] got=%h exp=%h", k, flit_q[k], exp_flits[k]); end
    end
    exp_sent++;
    total++; if (pkt_sent !== 16'(exp_sent)) begin bad++; $display("FAIL trunc_pkt_sent got=%0d exp=%0d", pkt_sent, exp_sent); end
  endtask

  task automatic test_eject_backpressure();
    logic [15:0] w[10];
    link.rx_ready = 1'b0;
    ej_q.delete();
    for (int k = 0; k < 10; k++) w[k] = 16'($urandom);
    send_flit(ADDR);
    send_flit(16'd10);
    for (int k = 0; k < 8; k++) send_flit(w[k]);
    link.router_tx = 1'b1; link.router_tx_data = w[8];
    step(); step();
    total++; if (link.ni_credit !== 1'b0 || acc_ej) begin
      bad++; $display("FAIL bp_credit got=%b exp=0", link.ni_credit); end
    link.rx_ready = 1'b1;
    send_flit(w[8]);
    send_flit(w[9]);
    wait_eject(10);
    total++; if (ej_q.size() !== 10) begin bad++; $display("FAIL bp_count got=%0d exp=10", ej_q.size()); end
    for (int k = 0; k < 10 && k < ej_q.size(); k++) begin
      total++; if (ej_q[k] !== {(k == 9), w[k]}) begin bad++; $display("FAIL bp_word[%0d] got=%h exp=%h", k, ej_q[k], {(k == 9), w[k]}); end
    end
    exp_recv++;
    total++; if (pkt_recv !== 16'(exp_recv)) begin bad++; $display("FAIL bp_pkt_recv got=%0d exp=%0d", pkt_recv, exp_recv); end
  endtask

  task automatic test_misroute();
    logic [15:0] w;
    link.rx_ready = 1'b1;
    ej_q.delete();
    send_flit(ADDR ^ 16'h0100);
    send_flit(16'd0);
    repeat (3) step();
    exp_recv++; exp_mis = 1;
    total++; if (misroute !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", misroute); end
    total++; if (pkt_recv !== 16'(exp_recv)) begin bad++; $display("FAIL mis_pkt_recv got=%0d exp=%0d", pkt_recv, exp_recv); end
    total++; if (ej_q.size() !== 0) begin bad++; $display("FAIL mis_no_word got=%0d exp=0", ej_q.size()); end
    w = 16'($urandom);
    send_flit(ADDR); send_flit(16'd1); send_flit(w);
    wait_eject(1);
    exp_recv++;
    total++; if (misroute !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b exp=1", misroute); end
    total++; if (ej_q.size() !== 1 || ej_q[0] !== {1'b1, w}) begin bad++; $display("FAIL mis_next_pkt got=%0d exp=1 word", ej_q.size()); end
  endtask

  task automatic test_random();
    int n;
    logic [15:0] hdr, f;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        rand_credit = 1'b1;
        flit_q.delete();
        trunc_cnt = 0;
        n = $urandom_range(1, TXD);
        inject_pkt(16'($urandom), n, 1'b1, 1'b1);
        wait_flits(exp_flits.size());
        rand_credit = 1'b0;
        exp_sent++;
        total++; if (flit_q.size() !== exp_flits.size()) begin bad++; $display("FAIL rnd_inj_len got=%0d exp=%0d", flit_q.size(), exp_flits.size()); end
        for (int k = 0; k < exp_flits.size() && k < flit_q.size(); k++) begin
          total++; if (flit_q[k] !== exp_flits[k]) begin bad++; $display("FAIL rnd_inj_flit[%0d] got=%h exp=%h", k, flit_q[k], exp_flits[k]); end
        end
        total++; if (trunc_cnt !== 0 || pkt_sent !== 16'(exp_sent)) begin
          bad++; $display("FAIL rnd_inj_status got=%0d/%0d exp=0/%0d", trunc_cnt, pkt_sent, exp_sent); end
      end else begin
        rand_ready = 1'b1;
        ej_q.delete();
        exp_ej.delete();
        n = $urandom_range(0, 12);
        hdr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ADDR;
        if (hdr != ADDR) exp_mis = 1;
        send_flit(hdr);
        send_flit(16'(n));
        for (int k = 0; k < n; k++) begin
          f = 16'($urandom);
          exp_ej.push_back({(k == n - 1), f});
          send_flit(f);
        end
        wait_eject(n);
        rand_ready = 1'b0;
        exp_recv++;
        total++; if (ej_q.size() !== exp_ej.size()) begin bad++; $display("FAIL rnd_ej_len got=%0d exp=%0d", ej_q.size(), exp_ej.size()); end
        for (int k = 0; k < exp_ej.size() && k < ej_q.size(); k++) begin
          total++; if (ej_q[k] !== exp_ej[k]) begin bad++; $display("FAIL rnd_ej_word[%0d] got=%h exp=%h", k, ej_q[k], exp_ej[k]); end
        end
        total++; if (pkt_recv !== 16'(exp_recv) || misroute !== exp_mis) begin
          bad++; $display("FAIL rnd_ej_status got=%0d/%b exp=%0d/%b", pkt_recv, misroute, exp_recv, exp_mis); end
      end
    end
  endtask

  task automatic test_reset_mid_pay();
    link.router_credit = 1'b1;
    link.rx_ready = 1'b0;
    flit_q.delete();
    inject_pkt(16'h0707, 6, 1'b1, 1'b0);
    wait_flits(4);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({link.router_rx, link.tx_ready, link.ni_credit, link.rx_valid} !== 4'b0) begin
      bad++; $display("FAIL midrst_hs got=%b exp=0000", {link.router_rx, link.tx_ready, link.ni_credit, link.rx_valid}); end
    total++; if (link.router_rx_data !== 16'h0) begin bad++; $display("FAIL midrst_data got=%h exp=0000", link.router_rx_data); end
    total++; if ({pkt_sent, pkt_recv} !== 32'h0 || misroute !== 1'b0) begin
      bad++; $display("FAIL midrst_status got=%h/%b exp=00000000/0", {pkt_sent, pkt_recv}, misroute); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_sent = 0; exp_recv = 0; exp_mis = 0;
    flit_q.delete();
    inject_pkt(16'h0405, 3, 1'b1, 1'b0);
    wait_flits(exp_flits.size());
    repeat (2) step();
    total++; if (flit_q.size() !== exp_flits.size()) begin bad++; $display("FAIL clean_len got=%0d exp=%0d", flit_q.size(), exp_flits.size()); end
    for (int k = 0; k < exp_flits.size() && k < flit_q.size(); k++) begin
      total++; if (flit_q[k] !== exp_flits[k]) begin bad++; $display("FAIL clean_flit[%0d] got=%h exp=%h", k, flit_q[k], exp_flits[k]); end
    end
    exp_sent++;
    total++; if (pkt_sent !== 16'(exp_sent)) begin bad++; $display("FAIL clean_pkt_sent got=%0d exp=%0d", pkt_sent, exp_sent); end
  endtask

  initial begin
    test_reset();
    test_inject_basic();
    test_credit_stall();
    test_truncate();
    test_eject_backpressure();
    test_misroute();
    test_random();
    test_reset_mid_pay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
